fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 24000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD, integer truncation (208 at defaults).
REQ-003 SHALL have parameter FRAME_LEN, default 64, payload bytes per frame (1..65535).
REQ-004 SHALL have parameter HEADER, default 8'hA5, sync byte sent before each frame.
REQ-005 SHALL have parameter HDR_EN, default 1, 1 = insert header, 0 = raw byte stream.
REQ-006 One clock; reset is synchronous and active-high; ports are named clk and rst.
REQ-007 clk  input  1  system clock; all logic on the rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 en  input  1  transmit enable; sampled only in IDLE.
REQ-010 fifo_empty  input  1  upstream FIFO empty_flag.
REQ-011 fifo_do  input  8  upstream FIFO read data; valid the cycle after fifo_re=1 (unregistered FIFO output).
REQ-012 fifo_re  output  1  upstream FIFO read enable; single-cycle pulse per byte.
REQ-013 uart_tx  output  1  serial line, idle high, 8N1, LSB first.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 tx_done  output  1  one-cycle pulse on the last cycle of every stop bit, header or payload.

Function
REQ-016 SHALL implement states IDLE, FETCH, LOAD, START, DATA, STOP.
REQ-017 IDLE: if en=1 and fifo_empty=0 and HDR_EN=1 and hdr_sent=0 -> load shift register with HEADER, set hdr_sent, go to START, no fifo_re.
REQ-018 IDLE: else if en=1 and fifo_empty=0 -> FETCH; otherwise remain in IDLE.
REQ-019 FETCH lasts exactly 1 cycle; fifo_re=1 only in FETCH (combinational decode of state); next state LOAD.
REQ-020 LOAD lasts 1 cycle; captures fifo_do into the shift register; next state START.
REQ-021 START drives uart_tx=0 for CLKS_PER_BIT cycles; DATA drives 8 bits LSB first, CLKS_PER_BIT cycles each; STOP drives uart_tx=1 for CLKS_PER_BIT cycles, then IDLE.
REQ-022 uart_tx SHALL be registered, glitch-free, and high in IDLE, FETCH and LOAD.
REQ-023 Bit timer counts 0..CLKS_PER_BIT-1 and restarts at every bit boundary; bit index counts 0..7.
REQ-024 Payload counter increments at the end of each payload stop bit; at FRAME_LEN-1 it wraps to 0 and clears hdr_sent.
REQ-025 Header is sent only when at least one payload byte is available (fifo_empty=0 in IDLE).
REQ-026 en deasserted mid-byte: the current byte completes; the block then stays in IDLE; frame counters are retained.
REQ-027 fifo_empty is not re-checked in FETCH/LOAD; the FIFO's empty/re guard protects against underflow.
REQ-028 Back-to-back bytes: the minimum gap between a stop-bit end and the next start bit is 3 cycles for payload (IDLE, FETCH, LOAD) and 1 cycle after a header.
REQ-029 HDR_EN=0: hdr_sent is ignored and no header is ever emitted.

Reset
REQ-030 rst=1 at a clock edge: state=IDLE, uart_tx=1, fifo_re=0, busy=0, tx_done=0, payload counter=0, hdr_sent=0, timers=0.
REQ-031 Reset mid-byte aborts the transfer; uart_tx=1 on the next cycle; the byte already read from the FIFO is discarded.
REQ-032 rst takes priority over every other input.

Verification (CLK_FREQ=1000, BAUD=100, CLKS_PER_BIT=10, FRAME_LEN=2)
REQ-033 FIFO preloaded with 8'h3C, en=1 -> waveform: header A5, then 3C; each bit is 10 cycles; exactly 1 fifo_re pulse; 2 tx_done pulses.
REQ-034 FIFO preloaded with 11,22,33 -> output sequence A5 11 22 A5 33; fifo_re pulses=3.
REQ-035 HDR_EN=0, FIFO preloaded with 55 -> only 55 is sent; fifo_re rises 1 cycle after IDLE and the start bit begins 2 cycles after fifo_re.
REQ-036 en=0, fifo_empty=0 -> uart_tx stays 1, busy=0, fifo_re never asserts; en dropped at DATA bit 3 -> the byte completes, then the line stays idle.
REQ-037 rst pulsed at DATA bit 4 -> uart_tx=1 the next cycle, busy=0; the next transfer starts with a header.
REQ-038 fifo_empty=1 throughout with en=1 -> no header is sent, no fifo_re pulses, uart_tx constant 1.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains bytes from an upstream FIFO onto an 8N1 serial line,
// optionally prefixing every FRAME_LEN payload bytes with a HEADER sync byte.
// Ports:
//   clk, rst    - system clock, synchronous active-high reset
//   en          - transmit enable, only looked at between bytes
//   fifo_empty  - upstream FIFO empty flag
//   fifo_do     - upstream FIFO data, valid the cycle after fifo_re
//   fifo_re     - one-cycle read strobe per payload byte
//   uart_tx     - registered serial output, idle high, LSB first
//   busy        - high whenever a byte is in flight
//   tx_done     - pulse on the last cycle of every stop bit
module fifo_uart_tx #(
    parameter int         CLK_FREQ  = 24000000,
    parameter int         BAUD      = 115200,
    parameter int         FRAME_LEN = 64,
    parameter logic [7:0] HEADER    = 8'hA5,
    parameter int         HDR_EN    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_do,
    output logic       fifo_re,
    output logic       uart_tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [15:0] PAY_LAST = 16'(FRAME_LEN - 1);
    localparam bit USE_HDR = (HDR_EN != 0);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state;
    logic [TW-1:0] timer;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic [15:0] pay_cnt;
    logic        hdr_sent;
    logic        is_hdr;
    logic        bit_end;

    assign bit_end = (timer == BIT_LAST);

    assign fifo_re = (state == FETCH);
    assign busy    = (state != IDLE);
    assign tx_done = (state == STOP) && bit_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            uart_tx  <= 1'b1;
            timer    <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            pay_cnt  <= '0;
            hdr_sent <= 1'b0;
            is_hdr   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    // Header only goes out once a payload byte is waiting,
                    // so an empty FIFO never produces a dangling sync byte.
                    if (en && !fifo_empty) begin
                        if (USE_HDR && !hdr_sent) begin
                            shreg    <= HEADER;
                            hdr_sent <= 1'b1;
                            is_hdr   <= 1'b1;
                            uart_tx  <= 1'b0;
                            state    <= START;
                        end else begin
                            is_hdr <= 1'b0;
                            state  <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    shreg   <= fifo_do;
                    uart_tx <= 1'b0;
                    state   <= START;
                end
                START: begin
                    if (bit_end) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        uart_tx <= shreg[0];
                        state   <= DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        timer <= '0;
                        // shreg[1] is the next bit once the shift lands
                        shreg <= {1'b0, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            uart_tx <= shreg[1];
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        timer <= '0;
                        state <= IDLE;
                        if (!is_hdr) begin
                            if (pay_cnt == PAY_LAST) begin
                                pay_cnt  <= '0;
                                hdr_sent <= 1'b0;
                            end else begin
                                pay_cnt <= pay_cnt + 16'd1;
                            end
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: two instances (header on / header off) driven from
// behavioural FIFOs, decoded by line monitors, compared to a stream model.
module tb_fifo_uart_tx;

    localparam int         FRAME_LEN = 2;
    localparam logic [7:0] HDR       = 8'hA5;

    typedef struct packed {
        logic             k;
        logic [3:0]       n;
        logic [7:0][7:0]  b;
        logic [3:0]       ere;
        logic [3:0]       edone;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [1:0] en = 2'b00;
    logic [1:0] fifo_empty;
    logic [1:0] fifo_re;
    logic [1:0] tx;
    logic [1:0] busy;
    logic [1:0] tx_done;
    logic [7:0] mem [2][256];
    int         wp [2] = '{0, 0};
    int         cyc = 0;
    int         pass_n = 0;
    int         chk_n = 0;
    logic [7:0] exp_b [64];
    logic       exp_h [64];
    int         exp_len = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : u
        int         rp = 0;
        logic [7:0] fdo = 8'h00;
        int         rxn = 0;
        int         fmt_err = 0;
        int         re_n = 0;
        int         done_n = 0;
        logic [7:0] rxb [1024];
        int         st [1024];

        assign fifo_empty[g] = (rp == wp[g]);

        fifo_uart_tx #(
            .CLK_FREQ (1000),
            .BAUD     (100),
            .FRAME_LEN(FRAME_LEN),
            .HEADER   (HDR),
            .HDR_EN   ((g == 0) ? 1 : 0)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .en        (en[g]),
            .fifo_empty(fifo_empty[g]),
            .fifo_do   (fdo),
            .fifo_re   (fifo_re[g]),
            .uart_tx   (tx[g]),
            .busy      (busy[g]),
            .tx_done   (tx_done[g])
        );

        always @(posedge clk) begin
            if (flush) begin
                rp <= wp[g];
            end else if (fifo_re[g] && rp != wp[g]) begin
                fdo <= mem[g][rp % 256];
                rp  <= rp + 1;
            end
        end

        always @(negedge clk) begin
            if (fifo_re[g]) re_n <= re_n + 1;
            if (tx_done[g]) done_n <= done_n + 1;
        end

        initial begin : mon
            logic       s [100];
            logic       d [100];
            logic       b [100];
            bit         ab;
            bit         ok;
            int         t0;
            logic [7:0] v;
            forever begin
                @(negedge clk);
                if (!rst && tx[g] == 1'b0) begin
                    t0 = cyc;
                    ab = 0;
                    s[0] = tx[g];
                    d[0] = tx_done[g];
                    b[0] = busy[g];
                    for (int i = 1; i < 100; i++) begin
                        @(negedge clk);
                        if (rst) begin
                            ab = 1;
                            break;
                        end
                        s[i] = tx[g];
                        d[i] = tx_done[g];
                        b[i] = busy[g];
                    end
                    if (!ab) begin
                        ok = 1;
                        for (int i = 0; i < 100; i++) begin
                            if (s[i] !== s[(i / 10) * 10]) ok = 0;
                            if (d[i] !== (i == 99)) ok = 0;
                            if (b[i] !== 1'b1) ok = 0;
                        end
                        if (s[0] !== 1'b0 || s[90] !== 1'b1) ok = 0;
                        for (int j = 0; j < 8; j++) v[j] = s[10 + 10 * j];
                        if (ok && rxn < 1024) begin
                            rxb[rxn] = v;
                            st[rxn] = t0;
                            rxn++;
                        end else begin
                            fmt_err++;
                        end
                    end
                end
            end
        end
    end

    function automatic int rx_n(input int k);
        return (k == 0) ? u[0].rxn : u[1].rxn;
    endfunction
    function automatic int rx_byte(input int k, input int i);
        return int'((k == 0) ? u[0].rxb[i] : u[1].rxb[i]);
    endfunction
    function automatic int rx_st(input int k, input int i);
        return (k == 0) ? u[0].st[i] : u[1].st[i];
    endfunction
    function automatic int n_re(input int k);
        return (k == 0) ? u[0].re_n : u[1].re_n;
    endfunction
    function automatic int n_done(input int k);
        return (k == 0) ? u[0].done_n : u[1].done_n;
    endfunction
    function automatic int n_fmt(input int k);
        return (k == 0) ? u[0].fmt_err : u[1].fmt_err;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        chk_n++;
        if (act == exp) pass_n++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b1;
        tick();
        rst = 1'b0;
        flush = 1'b0;
        tick();
    endtask

    task automatic push(input int k, input logic [7:0] v);
        mem[k][wp[k] % 256] = v;
        wp[k] = wp[k] + 1;
    endtask

    task automatic wait_low(input int k, output bit ok);
        ok = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (tx[k] == 1'b0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int k, output bit ok);
        ok = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (fifo_empty[k] && !busy[k]) begin
                ok = 1;
                break;
            end
        end
    endtask

    // Stream model from a fresh reset: a header opens every group of
    // FRAME_LEN payload bytes when the header is enabled.
    task automatic build_exp(input int k, input int n,
                             input logic [7:0][7:0] b);
        exp_len = 0;
        for (int i = 0; i < n; i++) begin
            if (k == 0 && (i % FRAME_LEN) == 0) begin
                exp_b[exp_len] = HDR;
                exp_h[exp_len] = 1'b1;
                exp_len++;
            end
            exp_b[exp_len] = b[i];
            exp_h[exp_len] = 1'b0;
            exp_len++;
        end
    endtask

    task automatic run_case(input int k, input int n,
                            input logic [7:0][7:0] b, input string nm,
                            output int re_d, output int done_d);
        bit ok;
        int r0, e0, d0, f0, got;
        en = 2'b00;
        do_reset();
        r0 = rx_n(k);
        e0 = n_re(k);
        d0 = n_done(k);
        f0 = n_fmt(k);
        build_exp(k, n, b);
        for (int i = 0; i < n; i++) push(k, b[i]);
        en[k] = 1'b1;
        wait_idle(k, ok);
        chk({nm, "_finish"}, int'(ok), 1);
        repeat (20) tick();
        en[k] = 1'b0;
        got = rx_n(k) - r0;
        chk({nm, "_nbytes"}, got, exp_len);
        for (int j = 0; j < exp_len && j < got; j++)
            chk({nm, "_byte"}, rx_byte(k, r0 + j), int'(exp_b[j]));
        for (int j = 1; j < exp_len && j < got; j++)
            chk({nm, "_gap"},
                rx_st(k, r0 + j) - rx_st(k, r0 + j - 1),
                100 + (exp_h[j] ? 1 : 3));
        chk({nm, "_fmt"}, n_fmt(k) - f0, 0);
        chk({nm, "_idle_tx"}, int'(tx[k]), 1);
        re_d = n_re(k) - e0;
        done_d = n_done(k) - d0;
    endtask

    initial begin
        vec_t            tbl [7];
        bit              ok;
        int              c0, cre, ctx, r0, e0, d0, bad;
        int              re_d, done_d, k, n;
        logic [7:0][7:0] rb;

        tbl[0] = '{k:1'b0, n:4'd1, b:64'h3C, ere:4'd1, edone:4'd2};
        tbl[1] = '{k:1'b0, n:4'd3, b:64'h332211, ere:4'd3, edone:4'd5};
        tbl[2] = '{k:1'b1, n:4'd1, b:64'h55, ere:4'd1, edone:4'd1};
        tbl[3] = '{k:1'b0, n:4'd0, b:64'h0, ere:4'd0, edone:4'd0};
        tbl[4] = '{k:1'b1, n:4'd0, b:64'h0, ere:4'd0, edone:4'd0};
        tbl[5] = '{k:1'b0, n:4'd4, b:64'hFF8001, ere:4'd4, edone:4'd6};
        tbl[6] = '{k:1'b1, n:4'd3, b:64'hFE01AA, ere:4'd3, edone:4'd3};

        rst = 1'b1;
        repeat (3) tick();
        chk("rst_tx", int'(tx), 3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_re", int'(fifo_re), 0);
        chk("rst_done", int'(tx_done), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_case(int'(tbl[i].k), int'(tbl[i].n), tbl[i].b,
                     $sformatf("vec%0d", i), re_d, done_d);
            chk($sformatf("vec%0d_re", i), re_d, int'(tbl[i].ere));
            chk($sformatf("vec%0d_txdone", i), done_d, int'(tbl[i].edone));
        end

        // raw mode latency: read one cycle after IDLE, start two after read
        en = 2'b00;
        do_reset();
        push(1, 8'h55);
        en[1] = 1'b1;
        c0 = cyc;
        cre = -1;
        ctx = -1;
        for (int c = 0; c < 200 && ctx < 0; c++) begin
            @(negedge clk);
            if (fifo_re[1] && cre < 0) cre = cyc;
            if (tx[1] == 1'b0 && ctx < 0) ctx = cyc;
        end
        chk("raw_re_lat", cre - c0, 1);
        chk("raw_start_lat", ctx - cre, 2);
        wait_idle(1, ok);
        chk("raw_finish", int'(ok), 1);
        en[1] = 1'b0;

        // en low with data waiting: nothing moves
        do_reset();
        r0 = rx_n(0);
        e0 = n_re(0);
        d0 = n_done(0);
        push(0, 8'h5A);
        bad = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || busy[0] || fifo_re[0]) bad++;
        end
        chk("en0_quiet", bad, 0);

        // en dropped at header DATA bit 3: header completes, then idle
        push(0, 8'h6B);
        en[0] = 1'b1;
        wait_low(0, ok);
        chk("drop_start", int'(ok), 1);
        repeat (45) @(negedge clk);
        en[0] = 1'b0;
        repeat (300) tick();
        chk("drop_nbytes", rx_n(0) - r0, 1);
        chk("drop_hdr", rx_byte(0, r0), 8'hA5);
        chk("drop_re", n_re(0) - e0, 0);
        chk("drop_busy", int'(busy[0]), 0);
        en[0] = 1'b1;
        wait_idle(0, ok);
        chk("resume_finish", int'(ok), 1);
        repeat (20) tick();
        en[0] = 1'b0;
        chk("resume_nbytes", rx_n(0) - r0, 3);
        chk("resume_b1", rx_byte(0, r0 + 1), 8'h5A);
        chk("resume_b2", rx_byte(0, r0 + 2), 8'h6B);
        chk("resume_re", n_re(0) - e0, 2);
        chk("resume_txdone", n_done(0) - d0, 3);

        // reset at payload DATA bit 4: byte lost, next transfer re-headers
        do_reset();
        r0 = rx_n(0);
        e0 = n_re(0);
        d0 = n_done(0);
        push(0, 8'h3C);
        push(0, 8'h7E);
        en[0] = 1'b1;
        wait_low(0, ok);
        chk("rst_hdr_start", int'(ok), 1);
        repeat (100) @(negedge clk);
        wait_low(0, ok);
        chk("rst_pay_start", int'(ok), 1);
        repeat (55) @(negedge clk);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_tx", int'(tx[0]), 1);
        chk("rst_mid_busy", int'(busy[0]), 0);
        wait_idle(0, ok);
        chk("rst_mid_finish", int'(ok), 1);
        repeat (20) tick();
        en[0] = 1'b0;
        chk("rst_mid_nbytes", rx_n(0) - r0, 3);
        chk("rst_mid_b0", rx_byte(0, r0), 8'hA5);
        chk("rst_mid_b1", rx_byte(0, r0 + 1), 8'hA5);
        chk("rst_mid_b2", rx_byte(0, r0 + 2), 8'h7E);
        chk("rst_mid_re", n_re(0) - e0, 2);
        chk("rst_mid_txdone", n_done(0) - d0, 3);

        for (int it = 0; it < 8; it++) begin
            k = int'($urandom_range(0, 1));
            n = int'($urandom_range(1, 6));
            rb = '0;
            for (int i = 0; i < n; i++) rb[i] = 8'($urandom);
            run_case(k, n, rb, $sformatf("rnd%0d", it), re_d, done_d);
            chk($sformatf("rnd%0d_re", it), re_d, n);
            chk($sformatf("rnd%0d_txdone", it), done_d, exp_len);
        end

        $display("%0d/%0d checks passed", pass_n, chk_n);
        $finish;
    end

endmodule
